sram_bridge: RTL and testbench

//  Parametrised memory-stage-to-SRAM bridge: one DATA_W-wide load/store from the ARM
//  MEM stage becomes BEATS = DATA_W/SRAM_DQ_W sequential SRAM accesses.

---
 rtl/sram_bridge_pkg.sv | 17 +
 rtl/sram_beat_timer.sv | 34 +++
 rtl/sram_bridge.sv | 87 ++++++++
 tb/tb_sram_bridge.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/sram_bridge_pkg.sv
// sram_defs: shared FSM encoding, SRAM bus defaults and sizing helpers for the SRAM bridge and model
package sram_defs;
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, DONE = 2'd2} state_t;
  localparam int SRAM_DQ_W_DEF = 16;
  localparam int SRAM_ADDR_W_DEF = 18;
  function automatic int beats(input int data_w, input int dq_w);
    return data_w / dq_w;
  endfunction
  function automatic int log2(input int v);
    int r = 0;
    for (int i = 1; i < 31; i++) r = (1 << i) <= v ? i : r;
    return r;
  endfunction
  function automatic int cw(input int n);
    return n > 1 ? log2(n - 1) + 1 : 1;
  endfunction
endpackage

// File: rtl/sram_beat_timer.sv
// sram_beat_timer: nested wait/beat counters pacing the SRAM beats of one transaction
//   clk, rst      clock, synchronous active-high reset
//   i_run         count while high, hold both counters at 0 while low
//   o_beat        current beat index
//   o_last_cycle  current cycle is the last of its beat
//   o_last_beat   current beat is the last of the transaction
module sram_beat_timer import sram_defs::*; #(
  parameter int BEATS = 2,
  parameter int WAIT_CYCLES = 2,
  localparam int BW = cw(BEATS),
  localparam int WW = cw(WAIT_CYCLES)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_run,
  output logic [BW-1:0] o_beat,
  output logic          o_last_cycle,
  output logic          o_last_beat
);
  logic [WW-1:0] r_wait;
  logic [BW-1:0] r_beat;
  assign o_beat = r_beat;
  assign o_last_cycle = r_wait == WW'(WAIT_CYCLES - 1);
  assign o_last_beat = r_beat == BW'(BEATS - 1);
  always_ff @(posedge clk) begin
    if (rst || !i_run) begin
      r_wait <= '0;
      r_beat <= '0;
    end else begin
      r_wait <= o_last_cycle ? '0 : r_wait + 1'b1;
      r_beat <= o_last_cycle ? (o_last_beat ? '0 : r_beat + 1'b1) : r_beat;
    end
  end
endmodule

// File: rtl/sram_bridge.sv
// sram_bridge: splits one DATA_W load/store into BEATS wait-stretched SRAM accesses, stalling via ready
//   clk, rst          clock, synchronous active-high reset
//   wr_en, rd_en      store/load request, held until ready (store wins when both)
//   addr, wdata       byte address (DATA_W/8 aligned), store data
//   rdata, ready      load data (valid in DONE), 0 = stall the pipeline
//   SRAM_*            external SRAM bus; DQ high-Z unless writing, control strobes tied low
module sram_bridge import sram_defs::*; #(
  parameter int DATA_W = 32,
  parameter int SRAM_DQ_W = SRAM_DQ_W_DEF,
  parameter int SRAM_ADDR_W = SRAM_ADDR_W_DEF,
  parameter int ADDR_W = 32,
  parameter int BASE_ADDR = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic                   ready,
  inout  wire  [SRAM_DQ_W-1:0]   SRAM_DQ,
  output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_UB_N,
  output logic                   SRAM_LB_N,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_OE_N
);
  localparam int BEATS = beats(DATA_W, SRAM_DQ_W);
  localparam int LG = log2(DATA_W / 8);
  localparam int BW = cw(BEATS);
  if (DATA_W % SRAM_DQ_W != 0 || WAIT_CYCLES < 1) begin : g_bad_params
    $error("sram_bridge: DATA_W must be a multiple of SRAM_DQ_W and WAIT_CYCLES >= 1");
  end
  state_t r_state, w_next;
  logic r_wr;
  logic [DATA_W-1:0] r_wdata;
  logic [SRAM_ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] w_word;
  logic [BW-1:0] w_beat;
  logic w_req, w_access, w_last_cycle, w_last_beat;
  assign w_req = rd_en || wr_en;
  assign w_access = r_state == ACCESS;
  assign w_word = (addr - ADDR_W'(BASE_ADDR)) >> LG;
  sram_beat_timer #(.BEATS(BEATS), .WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk(clk),
    .rst(rst),
    .i_run(w_access),
    .o_beat(w_beat),
    .o_last_cycle(w_last_cycle),
    .o_last_beat(w_last_beat)
  );
  always_comb begin
    w_next = r_state == IDLE ? (w_req ? ACCESS : IDLE) :
             r_state == ACCESS ? (w_last_cycle && w_last_beat ? DONE : ACCESS) : IDLE;
    ready = r_state == IDLE ? !w_req : r_state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else r_state <= w_next;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr <= 1'b0;
      r_wdata <= '0;
      r_base <= '0;
      rdata <= '0;
    end else begin
      if (r_state == IDLE && w_req) begin
        r_wr <= wr_en;
        r_wdata <= wdata;
        r_base <= SRAM_ADDR_W'(w_word * ADDR_W'(BEATS));
      end
      if (w_access && !r_wr && w_last_cycle) rdata[w_beat*SRAM_DQ_W +: SRAM_DQ_W] <= SRAM_DQ;
    end
  end
  assign SRAM_ADDR = r_base + SRAM_ADDR_W'(w_beat);
  // WE_N rises on the beat's final cycle so the SRAM latches data while DQ and address are still held
  assign SRAM_WE_N = !(w_access && r_wr && !w_last_cycle);
  assign SRAM_DQ = w_access && r_wr ? r_wdata[w_beat*SRAM_DQ_W +: SRAM_DQ_W] : 'z;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_OE_N = 1'b0;
endmodule

// File: tb/tb_sram_bridge.sv
// tb_sram_bridge: randomized self-checking bench for sram_bridge against a word-level SRAM reference
module tb_sram_bridge;
  logic clk = 1'b0;
  logic rst, preload, model_oe;
  logic wr_en, rd_en;
  logic [31:0] addr, wdata, rdata;
  logic ready, we_n, ub_n, lb_n, ce_n, oe_n;
  logic [17:0] sa;
  wire [15:0] dq;
  logic rd2, wr2;
  logic [31:0] addr2;
  logic [63:0] wdata2, rdata2;
  logic ready2, we2, ub2, lb2, ce2, oe2;
  logic [17:0] sa2;
  wire [15:0] dq2;
  logic [15:0] mem [0:262143];
  logic [15:0] ref_mem [0:262143];
  logic [31:0] ref_rdata;
  int n_cmp, n_bad;

  always #5 clk = ~clk;

  function automatic logic [15:0] fill(input logic [17:0] i);
    return (16'(i) * 16'h9E37) ^ 16'h5A5A;
  endfunction

  sram_bridge dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .SRAM_DQ(dq), .SRAM_ADDR(sa), .SRAM_WE_N(we_n),
    .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n), .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n)
  );

  sram_bridge #(.DATA_W(64), .WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst), .wr_en(wr2), .rd_en(rd2), .addr(addr2), .wdata(wdata2),
    .rdata(rdata2), .ready(ready2), .SRAM_DQ(dq2), .SRAM_ADDR(sa2), .SRAM_WE_N(we2),
    .SRAM_UB_N(ub2), .SRAM_LB_N(lb2), .SRAM_CE_N(ce2), .SRAM_OE_N(oe2)
  );

  assign dq = model_oe ? mem[sa] : 'z;
  assign dq2 = fill(sa2);

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 262144; i++) mem[i] <= fill(18'(i));
    else if (!we_n) mem[sa] <= dq;
  end

  task automatic txn(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d);
    int lat;
    logic [17:0] base;
    logic [31:0] exp_rd;
    base = 18'(((a - 32'd1024) >> 2) * 2);
    exp_rd = (r && !w) ? {ref_mem[18'(base + 18'd1)], ref_mem[base]} : ref_rdata;
    @(negedge clk);
    wr_en = w; rd_en = r; addr = a; wdata = d; model_oe = !w;
    #1;
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL req_ready: got %b want 0", ready); end
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready) break;
      if (lat <= 4) begin
        n_cmp++; if (sa !== 18'(base + 18'((lat - 1) / 2))) begin n_bad++; $display("FAIL addr: cycle %0d got %h want %h", lat, sa, 18'(base + 18'((lat - 1) / 2))); end
        n_cmp++; if (we_n !== ((w && (lat - 1) % 2 == 0) ? 1'b0 : 1'b1)) begin n_bad++; $display("FAIL we_n: cycle %0d got %b", lat, we_n); end
        if (w) begin
          n_cmp++; if (dq !== d[((lat - 1) / 2) * 16 +: 16]) begin n_bad++; $display("FAIL dq_drive: cycle %0d got %h want %h", lat, dq, d[((lat - 1) / 2) * 16 +: 16]); end
        end
      end
    end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL latency: got %0d want 5", lat); end
    n_cmp++; if (rdata !== exp_rd) begin n_bad++; $display("FAIL rdata: got %h want %h", rdata, exp_rd); end
    if (w) begin
      ref_mem[base] = d[15:0];
      ref_mem[18'(base + 18'd1)] = d[31:16];
      n_cmp++; if (mem[base] !== ref_mem[base]) begin n_bad++; $display("FAIL mem_lo: [%h] got %h want %h", base, mem[base], ref_mem[base]); end
      n_cmp++; if (mem[18'(base + 18'd1)] !== ref_mem[18'(base + 18'd1)]) begin n_bad++; $display("FAIL mem_hi: got %h want %h", mem[18'(base + 18'd1)], ref_mem[18'(base + 18'd1)]); end
    end else ref_rdata = exp_rd;
    @(negedge clk);
    n_cmp++; if (ready !== 1'b0) begin n_bad++; $display("FAIL done_once: got %b want 0", ready); end
    wr_en = 0; rd_en = 0; model_oe = 1;
    #1;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL idle_ready: got %b want 1", ready); end
  endtask

  task automatic test_reset;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL rst_ready: got %b want 1", ready); end
    n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL rst_we_n: got %b want 1", we_n); end
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL rst_rdata: got %h want 0", rdata); end
    n_cmp++; if (sa !== 18'h0) begin n_bad++; $display("FAIL rst_addr: got %h want 0", sa); end
    n_cmp++; if (dq !== ref_mem[0]) begin n_bad++; $display("FAIL rst_dq_idle: got %h want %h", dq, ref_mem[0]); end
    n_cmp++; if (ready2 !== 1'b1) begin n_bad++; $display("FAIL rst_ready2: got %b want 1", ready2); end
  endtask

  task automatic test_store_load;
    txn(1, 0, 32'd1024, 32'hDEADBEEF);
    n_cmp++; if (mem[0] !== 16'hBEEF || mem[1] !== 16'hDEAD) begin n_bad++; $display("FAIL store_words: got %h %h want beef dead", mem[0], mem[1]); end
    txn(0, 1, 32'd1024, 32'h0);
    n_cmp++; if (rdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL load_deadbeef: got %h", rdata); end
    txn(0, 1, 32'd1028, 32'h0);
  endtask

  task automatic test_both;
    txn(1, 1, 32'd1032, 32'h12345678);
    n_cmp++; if (mem[4] !== 16'h5678 || mem[5] !== 16'h1234) begin n_bad++; $display("FAIL both_words: got %h %h want 5678 1234", mem[4], mem[5]); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    wr_en = 1; addr = 32'd1024; wdata = 32'hA5A55A5A; model_oe = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1; wr_en = 0; model_oe = 1;
    @(negedge clk);
    ref_mem[0] = 16'h5A5A;
    n_cmp++; if (ready !== 1'b1) begin n_bad++; $display("FAIL mid_ready: got %b want 1", ready); end
    n_cmp++; if (we_n !== 1'b1) begin n_bad++; $display("FAIL mid_we_n: got %b want 1", we_n); end
    n_cmp++; if (sa !== 18'h0) begin n_bad++; $display("FAIL mid_addr: got %h want 0", sa); end
    n_cmp++; if (mem[0] !== ref_mem[0]) begin n_bad++; $display("FAIL mid_beat0: got %h want %h", mem[0], ref_mem[0]); end
    n_cmp++; if (mem[1] !== ref_mem[1]) begin n_bad++; $display("FAIL mid_beat1: got %h want %h", mem[1], ref_mem[1]); end
    rst = 0;
    ref_rdata = 32'h0;
    @(negedge clk);
    n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mid_rdata: got %h want 0", rdata); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 24; n++) begin
      int op;
      logic [31:0] a;
      op = $urandom_range(0, 2);
      a = ($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFFFFFC) : 32'd1024 + 32'($urandom_range(0, 63)) * 4;
      txn(op != 1, op != 0, a, $urandom);
    end
  endtask

  task automatic test_wide(input logic [31:0] a);
    int lat;
    logic [17:0] base;
    logic [63:0] exp_rd;
    base = 18'(((a - 32'd1024) >> 3) * 4);
    for (int b = 0; b < 4; b++) exp_rd[b*16 +: 16] = fill(18'(base + 18'(b)));
    @(negedge clk);
    rd2 = 1; addr2 = a;
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (ready2) break;
      n_cmp++; if (sa2 !== 18'(base + 18'(lat - 1))) begin n_bad++; $display("FAIL wide_addr: cycle %0d got %h want %h", lat, sa2, 18'(base + 18'(lat - 1))); end
      n_cmp++; if (we2 !== 1'b1) begin n_bad++; $display("FAIL wide_we_n: cycle %0d got %b", lat, we2); end
    end
    n_cmp++; if (lat !== 5) begin n_bad++; $display("FAIL wide_latency: got %0d want 5", lat); end
    n_cmp++; if (rdata2 !== exp_rd) begin n_bad++; $display("FAIL wide_rdata: got %h want %h", rdata2, exp_rd); end
    rd2 = 0;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    rst = 1; preload = 1; model_oe = 1;
    wr_en = 0; rd_en = 0; addr = 0; wdata = 0;
    wr2 = 0; rd2 = 0; addr2 = 0; wdata2 = 0;
    ref_rdata = 0;
    for (int i = 0; i < 262144; i++) ref_mem[i] = fill(18'(i));
    @(negedge clk);
    preload = 0;
    repeat (2) @(negedge clk);
    test_reset;
    rst = 0;
    @(negedge clk);
    test_reset;
    test_store_load;
    test_both;
    test_reset_mid;
    test_random;
    test_wide(32'd1024);
    for (int n = 0; n < 4; n++) test_wide(($urandom_range(0, 1) == 0) ? ($urandom & 32'hFFFFFFF8) : 32'd1024 + 32'($urandom_range(0, 63)) * 8);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
